// File: rtl/sort_pkg.sv
// Shared types and constants for the sort input loader.
//   WIDTH / DEPTH   : operand width and number of array entries
//   entry_t         : one operand
//   count_t         : number of valid entries, 0..DEPTH
//   loader_state_t  : loader FSM state
package sort_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  typedef logic [WIDTH-1:0] entry_t;
  typedef logic [3:0]       count_t;

  typedef enum logic {
    COLLECT = 1'b0,
    SORT    = 1'b1
  } loader_state_t;

endpackage

// File: rtl/btn_pulse.sv
// Raw button synchroniser followed by a registered rising-edge detector.
// A press held for any number of cycles yields exactly one 1-cycle pulse,
// asserted SYNC_STAGES+1 clocks after the raw rise.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_btn   : raw, asynchronous button level
//   o_pulse : single-cycle pulse per rising edge of i_btn
module btn_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev  <= w_level;
      // Registered so the pulse never has a combinational path from the pin.
      r_pulse <= w_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sort_input_loader.sv
// Upstream feeder for the sort stage. Collects operands entered on switches
// (one per enter press) into an array filled from the top index down, then
// freezes the array and raises sortEnable on a start press.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting entries; start with count >= 1 moves to SORT
// SORT    | array/count frozen, sortEnable/busy high until clear
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   dataIn         : switch value captured on an enter pulse
//   enterBtn       : raw button, capture dataIn
//   startBtn       : raw button, begin sort
//   clearBtn       : raw button, empty buffer and return to COLLECT
//   unsortedArray  : DEPTH entries to the sorter, first entry at DEPTH-1
//   count          : number of valid entries, 0..DEPTH
//   sortEnable     : high while in SORT
//   full           : count == DEPTH
//   busy           : high while in SORT
module sort_input_loader
  import sort_pkg::*;
#(
  parameter int WIDTH       = sort_pkg::WIDTH,
  parameter int DEPTH       = sort_pkg::DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            dataIn,
  input  logic                        enterBtn,
  input  logic                        startBtn,
  input  logic                        clearBtn,
  output logic [DEPTH-1:0][WIDTH-1:0] unsortedArray,
  output logic [3:0]                  count,
  output logic                        sortEnable,
  output logic                        full,
  output logic                        busy
);

  loader_state_t               r_state;
  loader_state_t               w_state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] r_array;
  logic [DEPTH-1:0][WIDTH-1:0] w_array_nxt;
  count_t                      r_count;
  count_t                      w_count_nxt;

  logic       w_en;
  logic       w_st;
  logic       w_cl;
  logic       w_full;
  logic [2:0] w_wr_idx;

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (enterBtn),
    .o_pulse (w_en)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (startBtn),
    .o_pulse (w_st)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (clearBtn),
    .o_pulse (w_cl)
  );

  assign w_full = (r_count == count_t'(DEPTH));

  // Entries fill from the top: first at DEPTH-1, next at DEPTH-2, ...
  // Only meaningful while not full.
  assign w_wr_idx = 3'(count_t'(DEPTH - 1) - r_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_array <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_array <= w_array_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Priority: clear, then start, then enter. A start that is honoured
  // drops a same-cycle enter.
  always_comb begin
    w_state_nxt = r_state;
    w_array_nxt = r_array;
    w_count_nxt = r_count;
    if (w_cl) begin
      w_state_nxt = COLLECT;
      w_array_nxt = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_st && (r_count != '0)) begin
            w_state_nxt = SORT;
          end else if (w_en && !w_full) begin
            w_array_nxt[w_wr_idx] = dataIn;
            w_count_nxt           = r_count + 4'd1;
          end
        end
        SORT: begin
          w_state_nxt = SORT;
        end
        default: begin
          w_state_nxt = COLLECT;
        end
      endcase
    end
  end

  assign unsortedArray = r_array;
  assign count         = r_count;
  assign full          = w_full;
  assign sortEnable    = (r_state == SORT);
  assign busy          = (r_state == SORT);

endmodule

// File: tb/tb_sort_input_loader.sv
module tb_sort_input_loader;

  logic             clk;
  logic             rst_n;
  logic [3:0]       dataIn;
  logic             enterBtn;
  logic             startBtn;
  logic             clearBtn;
  logic [7:0][3:0]  unsortedArray;
  logic [3:0]       count;
  logic             sortEnable;
  logic             full;
  logic             busy;

  sort_input_loader #(.WIDTH(4), .DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dataIn        (dataIn),
    .enterBtn      (enterBtn),
    .startBtn      (startBtn),
    .clearBtn      (clearBtn),
    .unsortedArray (unsortedArray),
    .count         (count),
    .sortEnable    (sortEnable),
    .full          (full),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] arr;
    logic [3:0]  cnt;
    logic        se;
    logic        fu;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compares the DUT against the oldest expectation on the
  // falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (unsortedArray !== e.arr || count !== e.cnt || sortEnable !== e.se ||
          full !== e.fu || busy !== e.bz) begin
        n_fail++;
        $display("FAIL %s: got arr=%h cnt=%0d se=%b full=%b busy=%b, want arr=%h cnt=%0d se=%b full=%b busy=%b",
                 e.name, unsortedArray, count, sortEnable, full, busy,
                 e.arr, e.cnt, e.se, e.fu, e.bz);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] arr, input logic [3:0] cnt,
                      input logic se, input logic fu, input logic bz);
    exp_t e;
    e.name = nm; e.arr = arr; e.cnt = cnt; e.se = se; e.fu = fu; e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bit0 = enter, bit1 = start, bit2 = clear. Called at posedge+1;
  // the effect is on the outputs 4 edges later (2 sync + edge detect + update).
  task automatic press(input logic [2:0] mask, input logic [3:0] val);
    dataIn   = val;
    enterBtn = mask[0];
    startBtn = mask[1];
    clearBtn = mask[2];
    tick(4);
    enterBtn = 1'b0;
    startBtn = 1'b0;
    clearBtn = 1'b0;
    tick(4);
  endtask

  initial begin
    int n;
    logic [3:0] vals5 [5];
    vals5 = '{4'd6, 4'd4, 4'd2, 4'd7, 4'd15};
    rst_n    = 1'b0;
    dataIn   = 4'd0;
    enterBtn = 1'b0;
    startBtn = 1'b0;
    clearBtn = 1'b0;

    tick(1);
    push("reset_state", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    #1 rst_n = 1'b1;
    tick(3);
    push("idle", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Long hold: one capture only, value present at the pulse cycle.
    dataIn   = 4'd5;
    enterBtn = 1'b1;
    tick(1);
    dataIn = 4'd9;
    tick(9);
    push("hold_mid", 32'h9000_0000, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(10);
    enterBtn = 1'b0;
    tick(4);
    push("hold_20", 32'h9000_0000, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);

    press(3'b100, 4'd0);
    push("clear1", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Start with empty buffer is ignored.
    press(3'b010, 4'd0);
    push("start_empty", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    for (int i = 0; i < 5; i++) press(3'b001, vals5[i]);
    push("five_entries", 32'h6427_F000, 4'd5, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Start latency: sortEnable rises SYNC_STAGES+2 = 4 clocks after raw rise.
    startBtn = 1'b1;
    n = 0;
    while (!sortEnable && n < 20) begin
      tick(1);
      n++;
    end
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL start_latency: got %0d clocks, want 4", n);
    end
    startBtn = 1'b0;
    tick(4);
    push("sort_five", 32'h6427_F000, 4'd5, 1'b1, 1'b0, 1'b1);
    tick(1);

    press(3'b001, 4'd3);
    push("sort_enter_ignored", 32'h6427_F000, 4'd5, 1'b1, 1'b0, 1'b1);
    tick(1);
    press(3'b010, 4'd0);
    push("sort_start_ignored", 32'h6427_F000, 4'd5, 1'b1, 1'b0, 1'b1);
    tick(1);

    press(3'b100, 4'd0);
    push("clear_from_sort", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Nine enters: eighth fills, ninth ignored.
    for (int i = 1; i <= 8; i++) press(3'b001, 4'(i));
    push("eight_full", 32'h1234_5678, 4'd8, 1'b0, 1'b1, 1'b0);
    tick(1);
    press(3'b001, 4'd9);
    push("ninth_ignored", 32'h1234_5678, 4'd8, 1'b0, 1'b1, 1'b0);
    tick(1);

    press(3'b100, 4'd0);
    push("clear_full", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Same-cycle start and enter with count 2: start wins, enter dropped.
    press(3'b001, 4'hA);
    press(3'b001, 4'hB);
    push("two_entries", 32'hAB00_0000, 4'd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    press(3'b011, 4'hC);
    push("start_beats_enter", 32'hAB00_0000, 4'd2, 1'b1, 1'b0, 1'b1);
    tick(1);

    // Clear overrides a same-cycle start and enter.
    press(3'b111, 4'hD);
    push("clear_beats_all", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Asynchronous reset in SORT.
    press(3'b001, 4'd3);
    press(3'b010, 4'd0);
    push("sort_before_reset", 32'h3000_0000, 4'd1, 1'b1, 1'b0, 1'b1);
    tick(1);
    push("async_reset", 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    tick(1);
    #1 rst_n = 1'b1;
    tick(2);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_input_loader.md
Name: sort_input_loader

Overview:
- Upstream feeder for the sort stage (sortMainTester).
- Collects 4-bit operands entered on switches, one per press of an enter button, into an 8-entry array and tracks how many are valid.
- On a start press, freezes the array and raises sortEnable. The sorter consumes unsortedArray, count and sortEnable directly.
- Buttons are raw board inputs; this block synchronises them and turns each rising edge into a single-cycle pulse.

Parameters:
- WIDTH, 4, bits per entry.
- DEPTH, 8, number of entries. Only 8 is supported, so count stays 4 bits.
- SYNC_STAGES, 2, synchroniser flops per button input. Must be 2 or more.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- dataIn  input  WIDTH  switch value to capture.
- enterBtn  input  1  raw button; capture dataIn.
- startBtn  input  1  raw button; begin sort.
- clearBtn  input  1  raw button; empty buffer and return to collect.
- unsortedArray  output  WIDTH x DEPTH, indexed [DEPTH-1:0]  entries to the sorter.
- count  output  4  number of valid entries, 0..8.
- sortEnable  output  1  level; high while in SORT.
- full  output  1  count == DEPTH.
- busy  output  1  high in SORT.

Behaviour:
- Reset (rst_n low, asynchronous): state COLLECT, all unsortedArray entries 0, count 0, sortEnable 0, full 0, busy 0. Synchroniser and edge-detect flops clear to 0.
- Button path:
  - Each button passes through SYNC_STAGES flops, then a registered rising-edge detector.
  - A press held high any number of cycles yields exactly one 1-cycle pulse: enP, stP or clP.
  - The pulse is asserted SYNC_STAGES+1 clocks after the raw rise.
  - Its effect is visible on outputs one clock after the pulse.
- Capture ordering:
  - The first entry goes to index 7, the next to 6, and so on; write index = 7 - count.
  - Valid entries occupy [7 : 8-count]. Unfilled lower indices stay 0.
- State COLLECT:
  - enP with count < 8: unsortedArray[7-count] <= dataIn; count <= count+1.
  - enP with count == 8: ignored, array and count unchanged, full stays 1.
  - stP with count >= 1: go to SORT.
  - stP with count == 0: ignored.
  - dataIn is sampled at the pulse cycle, not at the raw press.
- State SORT:
  - sortEnable = 1, busy = 1.
  - Array and count frozen; enP and stP ignored.
  - Stays in SORT until clP.
- clP, in any state: next cycle state COLLECT, all entries 0, count 0, sortEnable 0.
- Simultaneous pulses, priority order: clP, then stP, then enP.
  - stP and enP in the same COLLECT cycle: go to SORT; the enter is dropped and count is unchanged.
  - clP overrides both.
- Outputs full, busy and sortEnable are decoded from registered state and count. No combinational path from any input.
- Reset asserted mid-SORT: sortEnable drops immediately (asynchronous). The sorter must treat sortEnable low as abort.

Decomposition:
- Shared package sort_pkg holds:
  - WIDTH and DEPTH constants.
  - typedef entry_t logic [WIDTH-1:0].
  - typedef enum logic {COLLECT, SORT} loader_state_t.
  - count_t logic [3:0].
- One sub-module, btn_pulse (SYNC_STAGES synchroniser plus rising-edge pulse), instantiated three times.

Test Plan:
- Reset then idle: all outputs 0; after raw enterBtn held for 20 cycles, count = 1 exactly, with the value captured at the pulse cycle.
- Enter 6, 4, 2, 7, 15 then start: unsortedArray[7:3] = 6, 4, 2, 7, 15; [2:0] = 0; count = 5; sortEnable rises SYNC_STAGES+2 clocks after the raw start rise.
- Nine enters with values 1..9: entries [7:0] = 1..8, count = 8, full = 1; the ninth is ignored.
- Start with count 0: no state change, sortEnable stays 0. In SORT, an enter with dataIn = 3 leaves array and count unchanged.
- Same-cycle start and enter with count 2: SORT, count stays 2. Then clear: next cycle count 0, array all 0, sortEnable 0.
- Assert rst_n low asynchronously mid-SORT (between clock edges): sortEnable and count go to 0 before the next clk edge.
